// File: rtl/ram_pkg.sv
// Shared constants for the 64x8 flop-based scratch RAM.
package ram_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 6;
    localparam int DEPTH_DEF      = 1 << ADDR_WIDTH_DEF;

    localparam logic [7:0] RST_DATA = 8'h00;

endpackage

// File: rtl/ram_parity.sv
// Combinational even-parity generate (write side) and check (read side).
module ram_parity
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_inject,
    output logic                  wr_par,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_par,
    output logic                  rd_err
);

    // Inject flips the stored bit so a later read flags an error.
    assign wr_par = (^wr_data) ^ wr_inject;
    assign rd_err = ^{rd_data, rd_par};

endmodule

// File: rtl/ram.sv
// Single-port synchronous RAM, write-first, registered read, sync active-low reset.
// Optional per-word even parity is enabled by defining RAM_PARITY_EN.
module ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  write_enable,
    input  logic                  clk,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  rst_n,
`ifdef RAM_PARITY_EN
    input  logic                  parity_inject,
`endif
    output logic                  parity_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    always_comb begin
        mem_d      = mem_q;
        data_out_d = mem_q[address];
        if (write_enable) begin
            mem_d[address] = data_in;
            data_out_d     = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_WIDTH'(RST_DATA);
            end
            data_out_q <= DATA_WIDTH'(RST_DATA);
        end else begin
            mem_q      <= mem_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

`ifdef RAM_PARITY_EN
    logic par_q [DEPTH];
    logic par_d [DEPTH];
    logic parity_err_q, parity_err_d;
    logic wr_par, rd_err;

    ram_parity #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .wr_data  (data_in),
        .wr_inject(parity_inject),
        .wr_par   (wr_par),
        .rd_data  (mem_q[address]),
        .rd_par   (par_q[address]),
        .rd_err   (rd_err)
    );

    always_comb begin
        par_d        = par_q;
        parity_err_d = rd_err;
        if (write_enable) begin
            par_d[address] = wr_par;
            parity_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                par_q[i] <= 1'b0;
            end
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: vector table plus hand-written sequences, scoreboard queue.
module tb_ram;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic [5:0] address;
    logic       write_enable;
    logic [7:0] data_out;
    logic       parity_err;
`ifdef RAM_PARITY_EN
    logic       parity_inject;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst_n;
        logic       we;
        logic [5:0] addr;
        logic [7:0] din;
        logic       inj;
        logic [7:0] exp_d;
        logic       exp_p;
        string      name;
    } vec_t;

    typedef struct {
        logic [7:0] exp_d;
        logic       exp_p;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    ram dut (
        .data_in      (data_in),
        .address      (address),
        .write_enable (write_enable),
        .clk          (clk),
        .data_out     (data_out),
        .rst_n        (rst_n),
`ifdef RAM_PARITY_EN
        .parity_inject(parity_inject),
`endif
        .parity_err   (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic we, logic [5:0] a, logic [7:0] d,
                                logic inj, logic [7:0] ed, logic ep, string n);
        vec_t v;
        v.rst_n = r; v.we = we; v.addr = a; v.din = d; v.inj = inj;
        v.exp_d = ed; v.exp_p = ep; v.name = n;
        return v;
    endfunction

    // Drive away from the edge, push expectation, clock, then pop and compare.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst_n        = v.rst_n;
        write_enable = v.we;
        address      = v.addr;
        data_in      = v.din;
`ifdef RAM_PARITY_EN
        parity_inject = v.inj;
`endif
        e.exp_d = v.exp_d;
        e.exp_p = v.exp_p;
        e.name  = v.name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        total++;
        if (data_out !== got.exp_d || parity_err !== got.exp_p) begin
            bad++;
            $display("FAIL %s: data_out=%h parity_err=%b required data_out=%h parity_err=%b",
                     got.name, data_out, parity_err, got.exp_d, got.exp_p);
        end
    endtask

    initial begin
        rst_n = 1'b0; write_enable = 1'b0; address = '0; data_in = '0;
`ifdef RAM_PARITY_EN
        parity_inject = 1'b0;
`endif
        vecs.push_back(mk(0, 0, 6'd0,  8'h00, 0, 8'h00, 0, "reset"));
        vecs.push_back(mk(1, 0, 6'd0,  8'h00, 0, 8'h00, 0, "rd0_after_rst"));
        vecs.push_back(mk(1, 0, 6'd2,  8'h00, 0, 8'h00, 0, "rd2_after_rst"));
        vecs.push_back(mk(1, 0, 6'd63, 8'h00, 0, 8'h00, 0, "rd63_after_rst"));
        vecs.push_back(mk(1, 1, 6'd0,  8'h10, 0, 8'h10, 0, "wr0_first"));
        vecs.push_back(mk(1, 1, 6'd2,  8'h11, 0, 8'h11, 0, "wr2_first"));
        vecs.push_back(mk(1, 1, 6'd7,  8'hAF, 0, 8'hAF, 0, "wr7_first"));
        vecs.push_back(mk(1, 0, 6'd0,  8'hEE, 0, 8'h10, 0, "rd0"));
        vecs.push_back(mk(1, 0, 6'd2,  8'hEE, 0, 8'h11, 0, "rd2"));
        vecs.push_back(mk(1, 0, 6'd7,  8'hEE, 0, 8'hAF, 0, "rd7"));
        vecs.push_back(mk(1, 1, 6'd63, 8'h5A, 0, 8'h5A, 0, "wr63"));
        vecs.push_back(mk(1, 0, 6'd63, 8'h00, 0, 8'h5A, 0, "rd63"));
        vecs.push_back(mk(1, 0, 6'd0,  8'h00, 0, 8'h10, 0, "rd0_no_alias"));
        vecs.push_back(mk(1, 1, 6'd2,  8'hFF, 0, 8'hFF, 0, "wr2_ff"));
        vecs.push_back(mk(0, 1, 6'd2,  8'h33, 0, 8'h00, 0, "rst_over_wr"));
        vecs.push_back(mk(1, 0, 6'd2,  8'h00, 0, 8'h00, 0, "rd2_cleared"));
        vecs.push_back(mk(1, 0, 6'd7,  8'h00, 0, 8'h00, 0, "rd7_cleared"));
        vecs.push_back(mk(1, 0, 6'd63, 8'h00, 0, 8'h00, 0, "rd63_cleared"));
        vecs.push_back(mk(1, 1, 6'd5,  8'h22, 0, 8'h22, 0, "wr5"));
        vecs.push_back(mk(1, 0, 6'd5,  8'h00, 0, 8'h22, 0, "rd5_b2b"));

        foreach (vecs[i]) step(vecs[i]);

        // Alternate write/read every cycle, then re-read everything.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            d = 8'((i * 37 + 3) & 8'hFF);
            step(mk(1, 1, 6'(16 + i), d, 0, d, 0, "toggle_wr"));
            step(mk(1, 0, 6'(16 + i), 8'h00, 0, d, 0, "toggle_rd"));
        end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            d = 8'((i * 37 + 3) & 8'hFF);
            step(mk(1, 0, 6'(16 + i), 8'h00, 0, d, 0, "toggle_reread"));
        end

`ifdef RAM_PARITY_EN
        step(mk(1, 1, 6'd9, 8'h0F, 1, 8'h0F, 0, "par_wr_inject"));
        step(mk(1, 0, 6'd9, 8'h00, 0, 8'h0F, 1, "par_rd_err"));
        step(mk(1, 1, 6'd9, 8'h0F, 0, 8'h0F, 0, "par_wr_clean"));
        step(mk(1, 0, 6'd9, 8'h00, 0, 8'h0F, 0, "par_rd_clean"));
        step(mk(1, 1, 6'd10, 8'h07, 1, 8'h07, 0, "par_wr_odd_inject"));
        step(mk(1, 0, 6'd10, 8'h00, 0, 8'h07, 1, "par_rd_odd_err"));
        step(mk(0, 0, 6'd10, 8'h00, 0, 8'h00, 0, "par_rst"));
        step(mk(1, 0, 6'd10, 8'h00, 0, 8'h00, 0, "par_rd_after_rst"));
`endif

        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram.md
# ram

Single-port synchronous RAM, 64 words × 8 bits, with one clock, one shared address and a write enable. Writes and reads complete on the rising clock edge, and read data is registered. The block serves as a small general-purpose scratch store for datapath blocks. It is flop-based, so reset can clear the whole array.

## Interface
- DATA_WIDTH, default 8: word width in bits.
- ADDR_WIDTH, default 6: address width. Depth is 2**ADDR_WIDTH = 64 words.
- clk, input, 1 bit: clock. All activity is on the rising edge.
- rst_n, input, 1 bit: reset, synchronous and active-low.
- data_in, input, DATA_WIDTH bits: write data.
- address, input, ADDR_WIDTH bits: word address, used for both read and write.
- write_enable, input, 1 bit:
  - 1 means write data_in to address.
  - 0 means read address.
- data_out, output, DATA_WIDTH bits: registered read data.
- parity_inject, input, 1 bit: present only with RAM_PARITY_EN. When 1 during a write, the stored parity bit is inverted.
- parity_err, output, 1 bit: registered parity error flag, aligned with data_out. It is tied to 0 without RAM_PARITY_EN.
- Positional port order: data_in, address, write_enable, clk, data_out, rst_n, then parity_inject and parity_err.

## Operation
- Reset, when rst_n = 0 at a rising edge:
  - All 64 words are cleared to 0x00, with stored parity 0.
  - data_out becomes 0x00 and parity_err becomes 0.
  - Reset has priority over write_enable.
- Write, when rst_n = 1 and write_enable = 1:
  - mem[address] is set to data_in.
  - The array is write-first: data_out is set to data_in on the same edge.
- Read, when rst_n = 1 and write_enable = 0:
  - data_out is set to mem[address].
  - Memory is unchanged.
- data_out holds its value only while a reset, write or read is not occurring. Because every non-reset edge is either a write or a read, data_out therefore updates on every edge.
- Address range 0..63 covers the full space. There is no out-of-range case and no wrap logic.
- A read at the edge immediately after a write to the same address returns the new data.

## Timing
- Inputs are sampled at the rising edge. Drivers must change inputs away from that edge.
- Write latency: stored at edge N. A read issued at edge N+1 returns the new value after edge N+1.
- Read latency: 1 cycle. The address sampled at edge N produces data_out valid after edge N, held until edge N+1.
- Reset takes effect in 1 cycle. The first read or write is accepted on the first edge with rst_n = 1.
- If reset is asserted mid-sequence, the write on that edge is discarded and all prior contents are lost.
- There is no handshake. The block is always ready.

## Configuration
- RAM_PARITY_EN defined:
  - Each word stores an extra even-parity bit, ^data_in, XORed with parity_inject.
  - On a read, parity_err is set to XOR-reduction of {mem_data, mem_par}.
  - On a write, parity_err is set to 0.
  - On reset, parity_err is cleared to 0.
- RAM_PARITY_EN undefined:
  - There is no parity storage and no parity_inject port.
  - parity_err is constant 0.
  - Data behaviour is identical in both builds.

## Structure
- Shared package ram_pkg holds:
  - The DATA_WIDTH and ADDR_WIDTH defaults.
  - The derived DEPTH constant.
  - The reset data value 0x00.
- A single sub-module is natural: ram_parity, a combinational parity generate/check. It is instantiated only under RAM_PARITY_EN.
- The storage array and output register stay in the top module.

## Test plan
- Reset, then read addresses 0, 2 and 63 → data_out = 0x00 each cycle, parity_err = 0.
- Write 0x10@0, 0x11@2, 0xAF@7 on consecutive edges, then read 0, 2, 7 → data_out reads back 0x10, 0x11, 0xAF with 1-cycle latency. During each write cycle, data_out shows the written data.
- Write 0x5A@63, then read 63 on the next edge → data_out = 0x5A. Address 0 remains 0x10 (no aliasing).
- Write 0xFF@2, then assert rst_n = 0 with write_enable = 1 and data_in = 0x33 @2, then read 2 → data_out = 0x00 (reset wins, array cleared).
- Back-to-back write 0x22@5 then read 5 on the next edge → data_out = 0x22. Toggling write_enable every cycle shows no lost writes.
- With RAM_PARITY_EN:
  - Write 0x0F@9 with parity_inject = 1, then read 9 → data_out = 0x0F, parity_err = 1.
  - Rewrite 0x0F@9 with parity_inject = 0 and read → parity_err = 0.
